pipe_hazard_tracker: RTL and testbench

Pipeline-side counterpart of the MIPS 5-stage controller. It consumes the controller's per-stage reset/enable strobes and ID-stage decode outputs. It carries the write-back and memory control fields down the EXE, MEM and WB pipeline registers, and returns the valid flags and destination-register feedback the controller uses for forwarding and load-use stalls. It also keeps bubble and retirement counters for the debug display.

---
 rtl/pipe_hazard_tracker_pkg.sv | 41 ++++
 rtl/pipe_hazard_tracker_if.sv | 58 +++++
 rtl/pipe_hazard_tracker_stage_reg.sv | 20 ++
 rtl/pipe_hazard_tracker.sv | 98 +++++++++
 tb/tb_pipe_hazard_tracker.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared types for the pipeline-side hazard tracker:
// destination-select encodings and the per-stage carried fields.
package pipe_hazard_tracker_pkg;

  typedef enum logic [1:0] {
    WB_ADDR_RD   = 2'd0,
    WB_ADDR_RT   = 2'd1,
    WB_ADDR_LINK = 2'd2,
    WB_ADDR_NONE = 2'd3
  } wb_addr_e;

  localparam logic [4:0] REG_LINK = 5'd31;

  // valid must stay the MSB: stage registers gate on it
  typedef struct packed {
    logic       valid;
    logic [4:0] waddr;
    logic       wen;
    logic       ren;
    logic       wwen;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

  function automatic logic [4:0] resolve_waddr(
    input logic [1:0] src,
    input logic [4:0] rd,
    input logic [4:0] rt
  );
    logic [4:0] a;
    a = '0;
    unique case (1'b1)
      (src == WB_ADDR_RD):   a = rd;
      (src == WB_ADDR_RT):   a = rt;
      (src == WB_ADDR_LINK): a = REG_LINK;
      default:               a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/pipe_hazard_tracker_if.sv
// Controller <-> tracker bundle: stage strobes and ID decode in,
// valid flags, destination feedback and debug counters out.
interface pipe_hazard_tracker_if #(
  parameter int CNT_W = 32
);
  logic             if_rst, if_en;
  logic             id_rst, id_en;
  logic             exe_rst, exe_en;
  logic             mem_rst, mem_en;
  logic             wb_rst, wb_en;
  logic [31:0]      inst;
  logic             wb_wen;
  logic [1:0]       wb_addr_src;
  logic             mem_ren;
  logic             mem_wen;
  logic             if_valid, id_valid;
  logic             exe_valid, mem_valid, wb_valid;
  logic [4:0]       regw_addr_exe;
  logic [4:0]       regw_addr_mem;
  logic [4:0]       regw_addr_wb;
  logic             wb_wen_exe, wb_wen_mem, wb_wen_wb;
  logic             mem_ren_mem, mem_wen_mem;
  logic             is_load_exe;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output if_rst, if_en, id_rst, id_en,
    output exe_rst, exe_en, mem_rst, mem_en,
    output wb_rst, wb_en,
    output inst, wb_wen, wb_addr_src,
    output mem_ren, mem_wen,
    input  if_valid, id_valid,
    input  exe_valid, mem_valid, wb_valid,
    input  regw_addr_exe, regw_addr_mem,
    input  regw_addr_wb,
    input  wb_wen_exe, wb_wen_mem, wb_wen_wb,
    input  mem_ren_mem, mem_wen_mem,
    input  is_load_exe,
    input  retired_cnt, bubble_cnt
  );

  modport slave (
    input  if_rst, if_en, id_rst, id_en,
    input  exe_rst, exe_en, mem_rst, mem_en,
    input  wb_rst, wb_en,
    input  inst, wb_wen, wb_addr_src,
    input  mem_ren, mem_wen,
    output if_valid, id_valid,
    output exe_valid, mem_valid, wb_valid,
    output regw_addr_exe, regw_addr_mem,
    output regw_addr_wb,
    output wb_wen_exe, wb_wen_mem, wb_wen_wb,
    output mem_ren_mem, mem_wen_mem,
    output is_load_exe,
    output retired_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipe_hazard_tracker_stage_reg.sv
// One pipeline register: clear beats load beats hold.
// The output reads all-zero whenever the valid MSB is clear.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_clr)     r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q[W-1] ? r_q : '0;
endmodule

// File: rtl/pipe_hazard_tracker.sv
// Carries WB/MEM control down EXE/MEM/WB and feeds back
// valid flags and destinations for forwarding and stalls.
import pipe_hazard_tracker_pkg::*;

module pipe_hazard_tracker #(
  parameter int CNT_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  pipe_hazard_tracker_if.slave bus
);
  logic             r_if_valid;
  logic             r_id_valid;
  logic [CNT_W-1:0] r_retired_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [4:0]       w_waddr;
  stage_t           w_exe_d;
  stage_t           w_exe_q;
  stage_t           w_mem_q;
  stage_t           w_wb_q;

  assign w_waddr = resolve_waddr(bus.wb_addr_src,
                                 bus.inst[15:11],
                                 bus.inst[20:16]);

  // a zero destination never claims a write
  always_comb begin
    w_exe_d       = '0;
    w_exe_d.valid = r_id_valid;
    w_exe_d.waddr = w_waddr;
    w_exe_d.wen   = bus.wb_wen && (w_waddr != 5'd0);
    w_exe_d.ren   = bus.mem_ren;
    w_exe_d.wwen  = bus.mem_wen;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || bus.if_rst) r_if_valid <= 1'b0;
    else if (bus.if_en)      r_if_valid <= 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || bus.id_rst) r_id_valid <= 1'b0;
    else if (bus.id_en)      r_id_valid <= r_if_valid;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_retired_cnt <= '0;
      r_bubble_cnt  <= '0;
    end else begin
      if (w_wb_q.valid && bus.wb_en && !bus.wb_rst)
        r_retired_cnt <= r_retired_cnt + CNT_W'(1);
      if (bus.exe_rst)
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  pipe_stage_reg #(.W(STAGE_W)) u_exe (
    .i_clk (i_clk),
    .i_clr (i_rst | bus.exe_rst),
    .i_en  (bus.exe_en),
    .i_d   (w_exe_d),
    .o_q   (w_exe_q)
  );

  pipe_stage_reg #(.W(STAGE_W)) u_mem (
    .i_clk (i_clk),
    .i_clr (i_rst | bus.mem_rst),
    .i_en  (bus.mem_en),
    .i_d   (w_exe_q),
    .o_q   (w_mem_q)
  );

  pipe_stage_reg #(.W(STAGE_W)) u_wb (
    .i_clk (i_clk),
    .i_clr (i_rst | bus.wb_rst),
    .i_en  (bus.wb_en),
    .i_d   (w_mem_q),
    .o_q   (w_wb_q)
  );

  assign bus.if_valid      = r_if_valid;
  assign bus.id_valid      = r_id_valid;
  assign bus.exe_valid     = w_exe_q.valid;
  assign bus.mem_valid     = w_mem_q.valid;
  assign bus.wb_valid      = w_wb_q.valid;
  assign bus.regw_addr_exe = w_exe_q.waddr;
  assign bus.regw_addr_mem = w_mem_q.waddr;
  assign bus.regw_addr_wb  = w_wb_q.waddr;
  assign bus.wb_wen_exe    = w_exe_q.wen;
  assign bus.wb_wen_mem    = w_mem_q.wen;
  assign bus.wb_wen_wb     = w_wb_q.wen;
  assign bus.mem_ren_mem   = w_mem_q.ren;
  assign bus.mem_wen_mem   = w_mem_q.wwen;
  assign bus.is_load_exe   = w_exe_q.ren;
  assign bus.retired_cnt   = r_retired_cnt;
  assign bus.bubble_cnt    = r_bubble_cnt;
endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Bench for pipe_hazard_tracker: vector table, directed corner
// sequences and random traffic against a stage-array model.
module tb_pipe_hazard_tracker;
  localparam int CW = 32;
  localparam bit [4:0] ALL = 5'h1f;
  localparam logic [31:0] I_ADD3 = 32'h0022_1820;
  localparam logic [31:0] I_ORI5 = 32'h3405_0007;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_LW4  = 32'h8C04_0000;
  localparam logic [31:0] I_ADD5 = 32'h0084_2820;
  localparam logic [31:0] I_ADD0 = 32'h0022_0020;
  localparam logic [31:0] I_ADDI = 32'h2020_0001;
  localparam logic [31:0] I_SW   = 32'hAC04_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  pipe_hazard_tracker_if #(.CNT_W(CW)) bus ();
  pipe_hazard_tracker #(.CNT_W(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model: index 0..4 = IF, ID, EXE, MEM, WB
  bit          mv[5];
  logic [4:0]  ma[5];
  bit          mw[5], mr[5], ms[5];
  logic [CW-1:0] m_ret, m_bub;

  typedef struct {
    logic [31:0] inst;
    logic [1:0]  src;
    bit          wen;
    bit          ev;
    logic [4:0]  ea_exe;
    bit          ew_exe;
    logic [4:0]  ea_wb;
    bit          ew_wb;
    int          eret;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic model(bit r, bit [4:0] rs, bit [4:0] en,
                       logic [31:0] in, logic [1:0] src,
                       bit w, bit rd, bit wr);
    logic [4:0] a;
    if (r) begin
      for (int s = 0; s < 5; s++) begin
        mv[s] = 0; ma[s] = 0; mw[s] = 0; mr[s] = 0; ms[s] = 0;
      end
      m_ret = '0;
      m_bub = '0;
      return;
    end
    if (mv[4] && en[4] && !rs[4]) m_ret = m_ret + 1;
    if (rs[2]) m_bub = m_bub + 1;
    for (int s = 4; s >= 0; s--) begin
      if (rs[s]) begin
        mv[s] = 0; ma[s] = 0; mw[s] = 0; mr[s] = 0; ms[s] = 0;
      end else if (en[s]) begin
        if (s == 0) mv[0] = 1;
        else if (s == 1) mv[1] = mv[0];
        else if (s == 2) begin
          case (src)
            2'd0: a = in[15:11];
            2'd1: a = in[20:16];
            2'd2: a = 5'd31;
            default: a = 5'd0;
          endcase
          mv[2] = mv[1]; ma[2] = a; mw[2] = w && (a != 0);
          mr[2] = rd; ms[2] = wr;
        end else begin
          mv[s] = mv[s-1]; ma[s] = ma[s-1]; mw[s] = mw[s-1];
          mr[s] = mr[s-1]; ms[s] = ms[s-1];
        end
      end
    end
  endtask

  task automatic step(bit r, bit [4:0] rs, bit [4:0] en,
                      logic [31:0] in, logic [1:0] src,
                      bit w, bit rd, bit wr);
    rst = r;
    bus.if_rst = rs[0];  bus.if_en = en[0];
    bus.id_rst = rs[1];  bus.id_en = en[1];
    bus.exe_rst = rs[2]; bus.exe_en = en[2];
    bus.mem_rst = rs[3]; bus.mem_en = en[3];
    bus.wb_rst = rs[4];  bus.wb_en = en[4];
    bus.inst = in; bus.wb_addr_src = src;
    bus.wb_wen = w; bus.mem_ren = rd; bus.mem_wen = wr;
    @(posedge clk);
    model(r, rs, en, in, src, w, rd, wr);
    #1;
  endtask

  task automatic nop();
    step(0, 0, ALL, 32'h0, 2'd0, 0, 0, 0);
  endtask

  task automatic check_all();
    chk("if_valid", 32'(bus.if_valid), 32'(mv[0]));
    chk("id_valid", 32'(bus.id_valid), 32'(mv[1]));
    chk("exe_valid", 32'(bus.exe_valid), 32'(mv[2]));
    chk("mem_valid", 32'(bus.mem_valid), 32'(mv[3]));
    chk("wb_valid", 32'(bus.wb_valid), 32'(mv[4]));
    chk("addr_exe", 32'(bus.regw_addr_exe), mv[2] ? 32'(ma[2]) : 0);
    chk("addr_mem", 32'(bus.regw_addr_mem), mv[3] ? 32'(ma[3]) : 0);
    chk("addr_wb", 32'(bus.regw_addr_wb), mv[4] ? 32'(ma[4]) : 0);
    chk("wen_exe", 32'(bus.wb_wen_exe), 32'(mv[2] & mw[2]));
    chk("wen_mem", 32'(bus.wb_wen_mem), 32'(mv[3] & mw[3]));
    chk("wen_wb", 32'(bus.wb_wen_wb), 32'(mv[4] & mw[4]));
    chk("ren_mem", 32'(bus.mem_ren_mem), 32'(mv[3] & mr[3]));
    chk("wwen_mem", 32'(bus.mem_wen_mem), 32'(mv[3] & ms[3]));
    chk("load_exe", 32'(bus.is_load_exe), 32'(mv[2] & mr[2]));
    chk("retired", bus.retired_cnt, m_ret);
    chk("bubble", bus.bubble_cnt, m_bub);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h0, 2'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0};
    tbl[1] = '{32'h0, 2'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0};
    tbl[2] = '{I_ADD3, 2'd0, 1, 1, 5'd3, 1, 5'd0, 0, 0};
    tbl[3] = '{I_ORI5, 2'd1, 1, 1, 5'd5, 1, 5'd0, 0, 0};
    tbl[4] = '{I_JAL, 2'd2, 1, 1, 5'd31, 1, 5'd3, 1, 0};
    tbl[5] = '{32'h0, 2'd0, 0, 1, 5'd0, 0, 5'd5, 1, 1};
    tbl[6] = '{32'h0, 2'd0, 0, 1, 5'd0, 0, 5'd31, 1, 2};
    tbl[7] = '{32'h0, 2'd0, 0, 1, 5'd0, 0, 5'd0, 0, 3};

    // reset state
    step(1, 0, ALL, 32'h0, 2'd0, 0, 0, 0);
    check_all();
    chk("rst wb_valid", 32'(bus.wb_valid), 0);
    chk("rst retired", bus.retired_cnt, 0);
    chk("rst bubble", bus.bubble_cnt, 0);

    // free-run vector table
    for (int i = 0; i < 8; i++) begin
      step(0, 0, ALL, tbl[i].inst, tbl[i].src, tbl[i].wen, 0, 0);
      chk($sformatf("t%0d exe_valid", i), 32'(bus.exe_valid), 32'(tbl[i].ev));
      chk($sformatf("t%0d addr_exe", i), 32'(bus.regw_addr_exe), 32'(tbl[i].ea_exe));
      chk($sformatf("t%0d wen_exe", i), 32'(bus.wb_wen_exe), 32'(tbl[i].ew_exe));
      chk($sformatf("t%0d addr_wb", i), 32'(bus.regw_addr_wb), 32'(tbl[i].ea_wb));
      chk($sformatf("t%0d wen_wb", i), 32'(bus.wb_wen_wb), 32'(tbl[i].ew_wb));
      chk($sformatf("t%0d retired", i), bus.retired_cnt, 32'(tbl[i].eret));
      check_all();
    end

    // load-use stall
    step(1, 0, ALL, 32'h0, 2'd0, 0, 0, 0);
    nop(); nop();
    step(0, 0, ALL, I_LW4, 2'd1, 1, 1, 0);
    chk("lw load_exe", 32'(bus.is_load_exe), 1);
    step(0, 5'b00100, 5'b11100, I_ADD5, 2'd0, 1, 0, 0);
    chk("stall exe_valid", 32'(bus.exe_valid), 0);
    chk("stall load_exe", 32'(bus.is_load_exe), 0);
    chk("stall ren_mem", 32'(bus.mem_ren_mem), 1);
    chk("stall bubble", bus.bubble_cnt, 1);
    check_all();
    step(0, 0, ALL, I_ADD5, 2'd0, 1, 0, 0);
    chk("post exe_valid", 32'(bus.exe_valid), 1);
    chk("post addr_exe", 32'(bus.regw_addr_exe), 5);
    check_all();

    // writes to $0 never enable
    step(1, 0, ALL, 32'h0, 2'd0, 0, 0, 0);
    nop(); nop();
    step(0, 0, ALL, I_ADD0, 2'd0, 1, 0, 0);
    chk("r0 exe_valid", 32'(bus.exe_valid), 1);
    step(0, 0, ALL, I_ADDI, 2'd3, 1, 0, 0);
    chk("r0 exe_valid2", 32'(bus.exe_valid), 1);
    for (int i = 0; i < 4; i++) begin
      chk("r0 wen_exe", 32'(bus.wb_wen_exe), 0);
      chk("r0 wen_mem", 32'(bus.wb_wen_mem), 0);
      chk("r0 wen_wb", 32'(bus.wb_wen_wb), 0);
      nop();
    end

    // reset beats enable in MEM
    step(1, 0, ALL, 32'h0, 2'd0, 0, 0, 0);
    nop(); nop();
    step(0, 0, ALL, I_SW, 2'd1, 0, 0, 1);
    chk("sw exe_valid", 32'(bus.exe_valid), 1);
    step(0, 5'b01000, ALL, 32'h0, 2'd0, 0, 0, 0);
    chk("memrst mem_valid", 32'(bus.mem_valid), 0);
    chk("memrst wwen", 32'(bus.mem_wen_mem), 0);
    check_all();

    // debug freeze
    step(1, 0, ALL, 32'h0, 2'd0, 0, 0, 0);
    nop(); nop();
    step(0, 0, ALL, I_ADD3, 2'd0, 1, 0, 0);
    step(0, 0, ALL, I_ORI5, 2'd1, 1, 0, 0);
    step(0, 0, ALL, I_JAL, 2'd2, 1, 0, 0);
    nop();
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 5'b0, $urandom, 2'($urandom), 1, 1, 1);
      check_all();
    end
    for (int i = 0; i < 5; i++) begin
      nop();
      check_all();
    end

    // reset mid-stream, then counter wrap
    step(1, 0, ALL, 32'h0, 2'd0, 0, 0, 0);
    step(0, 0, ALL, I_ADD3, 2'd0, 1, 0, 0);
    step(0, 0, ALL, I_ORI5, 2'd1, 1, 0, 0);
    step(0, 5'b00100, 5'b11100, I_ADD3, 2'd0, 1, 0, 0);
    step(0, 0, ALL, I_ADD3, 2'd0, 1, 0, 0);
    step(0, 0, ALL, I_ADD3, 2'd0, 1, 0, 0);
    check_all();
    step(1, 0, ALL, I_ADD3, 2'd0, 1, 0, 0);
    chk("mid if_valid", 32'(bus.if_valid), 0);
    chk("mid exe_valid", 32'(bus.exe_valid), 0);
    chk("mid mem_valid", 32'(bus.mem_valid), 0);
    chk("mid addr_mem", 32'(bus.regw_addr_mem), 0);
    chk("mid bubble", bus.bubble_cnt, 0);
    chk("mid retired", bus.retired_cnt, 0);
    for (int i = 0; i < 5; i++) nop();
    chk("wrap wb_valid", 32'(bus.wb_valid), 1);
    force dut.r_retired_cnt = '1;
    #1;
    release dut.r_retired_cnt;
    m_ret = '1;
    nop();
    chk("wrap retired", bus.retired_cnt, 0);

    // random traffic
    step(1, 0, ALL, 32'h0, 2'd0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      bit [4:0] rs, en;
      for (int s = 0; s < 5; s++) begin
        rs[s] = ($urandom_range(0, 7) == 0);
        en[s] = ($urandom_range(0, 3) != 0);
      end
      step($urandom_range(0, 39) == 0, rs, en, $urandom,
           2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
